// File: rtl/io_load_sequencer.sv
// Operand load / program launch sequencer: debounces the store and start buttons,
// writes keyboard operands into the CPU register file, then launches the sort program.
module io_load_sequencer #(
    parameter int BASE_ADDR  = 4,
    parameter int COUNT      = 8,
    parameter int START_ADDR = 31
) (
    input  logic        clk_cpu,
    input  logic        reset,
    input  logic        clear,
    input  logic        input_press,
    input  logic        start_press,
    input  logic [28:0] in_num,
    input  logic        done_flag,
    output logic        reg_we,
    output logic [4:0]  reg_addr,
    output logic [31:0] reg_wdata,
    output logic [2:0]  state,
    output logic [4:0]  loaded,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_INPUT   = 3'd0,
        S_RELEASE = 3'd1,
        S_READY   = 3'd2,
        S_START   = 3'd3,
        S_RUN     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [4:0] BASE_V  = 5'(BASE_ADDR);
    localparam logic [4:0] COUNT_V = 5'(COUNT);
    localparam logic [4:0] START_V = 5'(START_ADDR);

    state_t      state_reg, state_next;
    logic [4:0]  loaded_reg, loaded_next;
    logic        busy_reg;
    logic        armed_reg;

    logic [1:0]  raw_buttons;
    logic [5:0]  deb_bits;
    logic        in_pressed, in_released, start_pressed;

    assign raw_buttons = {start_press, input_press};

    // One 3-flop shift register per button; bits [2:0] = input, [5:3] = start.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
            logic [2:0] shift_reg;
            always_ff @(posedge clk_cpu or posedge reset) begin
                if (reset) begin
                    shift_reg <= 3'b000;
                end else begin
                    shift_reg <= {shift_reg[1:0], raw_buttons[gi]};
                end
            end
            assign deb_bits[gi*3 +: 3] = shift_reg;
        end
    endgenerate

    assign in_pressed    = &deb_bits[2:0];
    assign in_released   = ~|deb_bits[2:0];
    assign start_pressed = &deb_bits[5:3];

    // After reset a still-held store button must be released before it counts again.
    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            armed_reg <= 1'b0;
        end else if (in_released && !input_press) begin
            armed_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            state_reg  <= S_INPUT;
            loaded_reg <= 5'd0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            loaded_reg <= loaded_next;
            busy_reg   <= (state_next == S_START) || (state_next == S_RUN);
        end
    end

    always_comb begin
        state_next  = state_reg;
        loaded_next = loaded_reg;
        reg_we      = 1'b0;
        reg_addr    = 5'd0;
        reg_wdata   = 32'd0;

        case (state_reg)
            S_INPUT: begin
                if (in_pressed && armed_reg) begin
                    if (loaded_reg < COUNT_V) begin
                        reg_we      = 1'b1;
                        reg_addr    = BASE_V + loaded_reg;
                        reg_wdata   = {3'b000, in_num};
                        loaded_next = loaded_reg + 5'd1;
                    end
                    state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (loaded_reg >= COUNT_V) begin
                    state_next = S_READY;
                end else if (in_released) begin
                    state_next = S_INPUT;
                end
            end
            S_READY: begin
                if (start_pressed) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                reg_we     = 1'b1;
                reg_addr   = START_V;
                reg_wdata  = 32'hFFFF_FFFF;
                state_next = S_RUN;
            end
            S_RUN: begin
                if (done_flag) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_DONE;
            end
            default: begin
                state_next = S_INPUT;
            end
        endcase

        // Restart overrides everything, including a write that would happen this cycle.
        if (clear) begin
            state_next  = S_INPUT;
            loaded_next = 5'd0;
            reg_we      = 1'b0;
            reg_addr    = 5'd0;
            reg_wdata   = 32'd0;
        end
    end

    assign state  = state_reg;
    assign loaded = loaded_reg;
    assign busy   = busy_reg;

endmodule

// File: tb/tb_io_load_sequencer.sv
// Scoreboard bench for io_load_sequencer: stimulus queues expected IO writes,
// a negedge monitor pops and compares every write the DUT presents.
module tb_io_load_sequencer;

    logic        clk_cpu = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        input_press = 1'b0;
    logic        start_press = 1'b0;
    logic [28:0] in_num = 29'd0;
    logic        done_flag = 1'b0;
    logic        reg_we;
    logic [4:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [2:0]  state;
    logic [4:0]  loaded;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];

    io_load_sequencer #(.BASE_ADDR(4), .COUNT(8), .START_ADDR(31)) dut (
        .clk_cpu(clk_cpu), .reset(reset), .clear(clear),
        .input_press(input_press), .start_press(start_press),
        .in_num(in_num), .done_flag(done_flag),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .state(state), .loaded(loaded), .busy(busy)
    );

    always #5 clk_cpu = ~clk_cpu;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_cpu);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_write(input logic [4:0] addr, input logic [31:0] data);
        exp_q.push_back({addr, data});
    endtask

    // Press the store button; if a write is expected it targets 4+idx.
    task automatic press(input int val, input int hold, input int rel,
                         input bit expect_write, input int idx);
        in_num = 29'(val);
        if (expect_write) push_write(5'(4 + idx), 32'(val));
        input_press = 1'b1;
        tick(hold);
        input_press = 1'b0;
        check("write_taken", 32'(exp_q.size()), 32'd0);
        tick(rel);
    endtask

    task automatic press_start(input int hold, input int rel);
        start_press = 1'b1;
        tick(hold);
        start_press = 1'b0;
        tick(rel);
    endtask

    // Scoreboard monitor.
    always @(negedge clk_cpu) begin
        if (!reset) begin
            checks++;
            if (reg_we) begin
                $display("write addr=%0d data=%08h", reg_addr, reg_wdata);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data %08h, required no write",
                             reg_addr, reg_wdata);
                end else begin
                    logic [36:0] e;
                    e = exp_q.pop_front();
                    if ({reg_addr, reg_wdata} !== e) begin
                        errors++;
                        $display("FAIL write: got addr %0d data %08h, required addr %0d data %08h",
                                 reg_addr, reg_wdata, e[36:32], e[31:0]);
                    end
                end
            end else if (reg_addr !== 5'd0 || reg_wdata !== 32'd0) begin
                errors++;
                $display("FAIL idle_zero: got addr %0d data %08h, required 0 0", reg_addr, reg_wdata);
            end
        end
    end

    int vals[8] = '{7, 3, 9, 1, 0, 5, 2, 8};

    initial begin
        #1 reset = 1'b1;
        #2;
        check("rst_state", 32'(state), 32'd0);
        check("rst_loaded", 32'(loaded), 32'd0);
        check("rst_we", 32'(reg_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(2);

        // Glitch shorter than the debounce window.
        input_press = 1'b1;
        tick(2);
        input_press = 1'b0;
        tick(5);
        check("glitch_state", 32'(state), 32'd0);
        check("glitch_loaded", 32'(loaded), 32'd0);

        for (int i = 0; i < 3; i++) press(vals[i], 5, 5, 1'b1, i);

        // Early start is ignored.
        press_start(5, 5);
        check("early_state", 32'(state), 32'd0);
        check("early_loaded", 32'(loaded), 32'd3);

        // Held button: exactly one write, waits in RELEASE.
        in_num = 29'(vals[3]);
        push_write(5'd7, 32'(vals[3]));
        input_press = 1'b1;
        tick(10);
        check("held_state_a", 32'(state), 32'd1);
        tick(30);
        check("held_state_b", 32'(state), 32'd1);
        check("held_write", 32'(exp_q.size()), 32'd0);
        input_press = 1'b0;
        tick(2);
        check("held_state_c", 32'(state), 32'd1);
        tick(3);
        check("held_released", 32'(state), 32'd0);

        // Simultaneous store and start: store wins.
        start_press = 1'b1;
        press(vals[4], 5, 0, 1'b1, 4);
        start_press = 1'b0;
        tick(5);
        check("simul_state", 32'(state), 32'd0);
        check("simul_loaded", 32'(loaded), 32'd5);

        for (int i = 5; i < 8; i++) press(vals[i], 5, 5, 1'b1, i);
        check("load_state", 32'(state), 32'd2);
        check("load_loaded", 32'(loaded), 32'd8);

        press(99, 5, 5, 1'b0, 0);
        check("ready_ignore", 32'(state), 32'd2);
        check("ready_loaded", 32'(loaded), 32'd8);

        // Launch.
        push_write(5'd31, 32'hFFFF_FFFF);
        start_press = 1'b1;
        tick(3);
        start_press = 1'b0;
        check("pre_start", 32'(state), 32'd2);
        tick(1);
        check("start_state", 32'(state), 32'd3);
        check("start_busy", 32'(busy), 32'd1);
        tick(1);
        check("run_state", 32'(state), 32'd4);
        check("run_busy", 32'(busy), 32'd1);
        check("start_write", 32'(exp_q.size()), 32'd0);
        tick(3);
        check("run_hold", 32'(state), 32'd4);
        done_flag = 1'b1;
        tick(1);
        done_flag = 1'b0;
        check("done_state", 32'(state), 32'd5);
        check("done_busy", 32'(busy), 32'd0);
        press_start(5, 5);
        press(42, 5, 5, 1'b0, 0);
        check("done_hold", 32'(state), 32'd5);

        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clr_done_state", 32'(state), 32'd0);
        check("clr_done_loaded", 32'(loaded), 32'd0);

        // Reload, launch, then clear in RUN.
        for (int i = 0; i < 8; i++) press(100 + i, 4, 4, 1'b1, i);
        check("reload_state", 32'(state), 32'd2);
        push_write(5'd31, 32'hFFFF_FFFF);
        press_start(3, 3);
        check("rerun_state", 32'(state), 32'd4);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clr_run_state", 32'(state), 32'd0);
        check("clr_run_loaded", 32'(loaded), 32'd0);
        check("clr_run_busy", 32'(busy), 32'd0);

        // Async reset in the middle of a write.
        press(55, 5, 5, 1'b1, 0);
        press(66, 5, 5, 1'b1, 1);
        in_num = 29'd77;
        input_press = 1'b1;
        tick(3);
        check("mid_we", 32'(reg_we), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("arst_we", 32'(reg_we), 32'd0);
        check("arst_addr", 32'(reg_addr), 32'd0);
        check("arst_data", reg_wdata, 32'd0);
        check("arst_state", 32'(state), 32'd0);
        check("arst_loaded", 32'(loaded), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(8);
        check("held_after_rst", 32'(state), 32'd0);
        check("held_after_rst_ld", 32'(loaded), 32'd0);
        input_press = 1'b0;
        tick(5);
        press(77, 5, 5, 1'b1, 0);
        check("post_rst_loaded", 32'(loaded), 32'd1);

        tick(5);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
